riscv_core_divider: RTL and testbench
=====================================

# riscv_core_divider

Iterative radix-2 restoring divider for the RV64M divide/remainder group (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It sits directly downstream of the mul/div control block:
- It is launched by that block's `div_start` pulse.
- It returns the final result plus a one-cycle `div_dn` done pulse.
- Operands are captured at start; the divider needs no upstream stability afterwards.

## Interface
Parameters:
- `XLEN`, 64: datapath width. Only 64 is supported.

Ports (clock and reset first):
- `i_mul_div_ctrl_clk`, in, 1: clock.
- `i_mul_div_ctrl_rstn`, in, 1: reset. Asynchronous, active-low.
- `i_div_start`, in, 1: launch pulse, honoured only in IDLE.
- `i_div_srcA`, in, XLEN: dividend.
- `i_div_srcB`, in, XLEN: divisor.
- `i_div_control`, in, 3: funct3. Bit 1 = remainder, bit 0 = unsigned; bit 2 is ignored.
- `i_div_isword`, in, 1: 32-bit (W) variant.
- `o_div_result`, out, XLEN: quotient or remainder, registered and held until the next accepted start.
- `o_div_done`, out, 1: one-cycle pulse while the result is valid.
- `o_div_busy`, out, 1: high whenever state is not IDLE.

## Operation
FSM states: IDLE, PREP, CALC, FIX, DONE.
- **IDLE**
  - When `i_div_start`=1: latch srcA, srcB, control[1:0] and isword, then go to PREP.
  - Start in any other state is ignored; latched operands are unchanged.
- **PREP** (1 cycle)
  - Operand width N = 32 if isword, else 64.
  - Word ops use srcA[31:0] and srcB[31:0]: sign-extended for signed ops, zero-extended for unsigned.
  - Signed ops: record `negA` and `negB` from bit N-1; convert operands to magnitudes (two's complement). |−2^(N-1)| is the unsigned value 2^(N-1).
  - Unsigned ops: magnitudes are the operands, and negA = negB = 0.
  - Clear the partial remainder R (XLEN+1 bits). Load quotient shift register Q with the dividend magnitude, left-aligned so its MSB is bit N-1 of the operand. Load the iteration counter with N-1.
  - Go to CALC.
- **CALC** (N cycles, one quotient bit per cycle)
  - T = {R, Q MSB}; D = T − divisor magnitude.
  - If D ≥ 0: R ← D and shift 1 into Q. Otherwise: R ← T and shift 0 into Q.
  - Decrement the counter; after the iteration at counter 0, go to FIX.
- **FIX** (1 cycle)
  - q = low N bits of Q; r = low N bits of R.
  - Negate q when negA≠negB **and** divisor ≠ 0.
  - Negate r when negA.
  - Select r if control[1], else q.
  - If isword, sign-extend bit 31 into bits 63:32; this applies to unsigned W ops too.
  - Register the value into `o_div_result`, then go to DONE.
- **DONE** (1 cycle): `o_div_done`=1, then go to IDLE.

Arithmetic results follow the RISC-V spec with no special-case logic:
- Divide by zero gives q = all ones and r = dividend.
- Signed overflow (−2^(N-1) / −1) gives q = −2^(N-1) and r = 0.

## Timing
- Reset (async, any state) → IDLE; `o_div_result`=0, `o_div_done`=0, `o_div_busy`=0. Partial results are discarded.
- Start sampled high at the edge ending cycle 0:
  - PREP = cycle 1.
  - CALC = cycles 2..N+1.
  - FIX = cycle N+2.
  - DONE = cycle N+3.
- Resulting latency: done asserted in cycle 67 (64-bit) or cycle 35 (word).
- `o_div_busy` is high in cycles 1..N+3 and low in cycle N+4.
- A new start in DONE is ignored. It is accepted in IDLE from cycle N+4 on, so the minimum start-to-start spacing is N+4 cycles.
- `o_div_result` changes only at the FIX→DONE edge and holds afterwards.

## Test plan
- **DIVU/REMU:** srcA=100, srcB=7, 64-bit → result 14 (DIVU) or 2 (REMU); done exactly in cycle 67, busy high in cycles 1..67.
- **Signed DIV/REM:** srcA=−7, srcB=2 → DIV 0xFFFF_FFFF_FFFF_FFFD; REM 0xFFFF_FFFF_FFFF_FFFF.
- **Overflow:** DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000; REM → 0.
- **Word ops:** DIVW srcA=0x1234_5678_FFFF_FFF9, srcB=2 → 0xFFFF_FFFF_FFFF_FFFD, done in cycle 35. DIVUW srcA=0xFFFF_FFFF, srcB=1 → 0xFFFF_FFFF_FFFF_FFFF.
- **Divide by zero:** DIV 5/0 → all ones; DIVU 5/0 → all ones; REM −5/0 → 0xFFFF_FFFF_FFFF_FFFB; REMW 7/0 → 7.
- **Robustness:**
  - Start pulsed again at CALC cycle 10 with different operands → ignored; the original result is produced.
  - rstn low at CALC cycle 20 → immediate IDLE with busy=0 and result=0; no done pulse.
  - A fresh start after reset completes normally.

Source files
------------

// File: rtl/riscv_core_divider.sv
// Iterative radix-2 restoring divider for the RV64M DIV/REM family, including W variants.
// One quotient bit per cycle; operands are captured on the accepted start.
module riscv_core_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_mul_div_ctrl_clk,
    input  logic            i_mul_div_ctrl_rstn,
    input  logic            i_div_start,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic [2:0]      i_div_control,
    input  logic            i_div_isword,
    output logic [XLEN-1:0] o_div_result,
    output logic            o_div_done,
    output logic            o_div_busy
);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] a_q, b_q, bmag, q_sr, result_q;
    logic [XLEN:0]   rem;
    logic [1:0]      ctrl_q;
    logic            word_q, neg_a, neg_b;
    logic [5:0]      cnt;
    logic            ctrl_unused;

    assign ctrl_unused = i_div_control[2];

    logic            is_signed, sa, sb;
    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;

    assign is_signed = ~ctrl_q[0];

    // Operand conditioning used in PREP: width select, extension, magnitude
    always_comb begin
        op_a = a_q;
        op_b = b_q;
        if (word_q) begin
            op_a = is_signed ? {{(XLEN-32){a_q[31]}}, a_q[31:0]} : {{(XLEN-32){1'b0}}, a_q[31:0]};
            op_b = is_signed ? {{(XLEN-32){b_q[31]}}, b_q[31:0]} : {{(XLEN-32){1'b0}}, b_q[31:0]};
        end
        sa    = is_signed & op_a[XLEN-1];
        sb    = is_signed & op_b[XLEN-1];
        mag_a = sa ? (~op_a + 1'b1) : op_a;
        mag_b = sb ? (~op_b + 1'b1) : op_b;
    end

    logic [XLEN+1:0] trial, diff;
    logic            ge;

    assign trial = {rem, q_sr[XLEN-1]};
    assign diff  = trial - {2'b00, bmag};
    assign ge    = ~diff[XLEN+1];

    logic [XLEN-1:0] q_n, r_n, sel, fin;

    always_comb begin
        q_n = word_q ? {{(XLEN-32){1'b0}}, q_sr[31:0]} : q_sr;
        r_n = word_q ? {{(XLEN-32){1'b0}}, rem[31:0]}  : rem[XLEN-1:0];
        if ((neg_a ^ neg_b) && (bmag != '0))
            q_n = ~q_n + 1'b1;
        if (neg_a)
            r_n = ~r_n + 1'b1;
        sel = ctrl_q[1] ? r_n : q_n;
        fin = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge i_mul_div_ctrl_clk or negedge i_mul_div_ctrl_rstn) begin
        if (!i_mul_div_ctrl_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_div_start) state_nxt = PREP;
            PREP:    state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_mul_div_ctrl_clk or negedge i_mul_div_ctrl_rstn) begin
        if (!i_mul_div_ctrl_rstn) begin
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            word_q   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            bmag     <= '0;
            rem      <= '0;
            q_sr     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_div_start) begin
                        a_q    <= i_div_srcA;
                        b_q    <= i_div_srcB;
                        ctrl_q <= i_div_control[1:0];
                        word_q <= i_div_isword;
                    end
                end
                PREP: begin
                    neg_a <= sa;
                    neg_b <= sb;
                    bmag  <= mag_b;
                    rem   <= '0;
                    // Word dividends sit in the top half so Q's MSB is always the next bit to consume
                    q_sr  <= word_q ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                    cnt   <= word_q ? 6'd31 : 6'd63;
                end
                CALC: begin
                    rem  <= ge ? diff[XLEN:0] : trial[XLEN:0];
                    q_sr <= {q_sr[XLEN-2:0], ge};
                    cnt  <= cnt - 6'd1;
                end
                FIX:     result_q <= fin;
                default: ;
            endcase
        end
    end

    assign o_div_result = result_q;
    assign o_div_done   = (state == DONE);
    assign o_div_busy   = (state != IDLE);

endmodule

// File: tb/tb_riscv_core_divider.sv
// Directed, table-driven bench for riscv_core_divider: results, latency, busy/done framing,
// start-while-busy immunity and mid-operation asynchronous reset.
module tb_riscv_core_divider;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [63:0] srcA = '0, srcB = '0;
    logic [2:0]  ctrl = '0;
    logic        isword = 1'b0;
    logic [63:0] result;
    logic        done, busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_exp = '0;

    always #5 clk = ~clk;

    riscv_core_divider #(.XLEN(64)) dut (
        .i_mul_div_ctrl_clk  (clk),
        .i_mul_div_ctrl_rstn (rstn),
        .i_div_start         (start),
        .i_div_srcA          (srcA),
        .i_div_srcB          (srcB),
        .i_div_control       (ctrl),
        .i_div_isword        (isword),
        .o_div_result        (result),
        .o_div_done          (done),
        .o_div_busy          (busy)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] exp;
        int          lat;
        int          inj;   // cycle at which a spurious start is pulsed, 0 = none
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   done_cyc;
        logic busy_ok, hold_ok;
        @(negedge clk);
        srcA = v.a; srcB = v.b; ctrl = v.f3; isword = v.w; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) done_cyc = k;
            else if (result !== last_exp) hold_ok = 1'b0;
            if (k == v.inj) begin
                srcA = 64'd999; srcB = 64'd3; ctrl = 3'b110; isword = 1'b1; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(v.lat));
        check({v.name, "_result"}, result, v.exp);
        check({v.name, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
        check({v.name, "_result_hold"}, {63'd0, hold_ok}, 64'd1);
        @(negedge clk);
        check({v.name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        check({v.name, "_result_kept"}, result, v.exp);
        last_exp = v.exp;
    endtask

    initial begin
        int no_done;

        vecs[0]  = '{"divu",        64'd100, 64'd7, 3'b101, 1'b0, 64'd14, 67, 0};
        vecs[1]  = '{"remu",        64'd100, 64'd7, 3'b111, 1'b0, 64'd2, 67, 0};
        vecs[2]  = '{"div_neg",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0};
        vecs[3]  = '{"rem_neg",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0};
        vecs[4]  = '{"div_ovf",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0, 64'h8000_0000_0000_0000, 67, 0};
        vecs[5]  = '{"rem_ovf",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 64'd0, 67, 0};
        vecs[6]  = '{"divw",        64'h1234_5678_FFFF_FFF9, 64'd2, 3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 35, 0};
        vecs[7]  = '{"divuw",       64'h0000_0000_FFFF_FFFF, 64'd1, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0};
        vecs[8]  = '{"div_by0",     64'd5, 64'd0, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0};
        vecs[9]  = '{"divu_by0",    64'd5, 64'd0, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0};
        vecs[10] = '{"rem_by0",     64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 67, 0};
        vecs[11] = '{"remw_by0",    64'd7, 64'd0, 3'b110, 1'b1, 64'd7, 35, 0};
        vecs[12] = '{"divw_ovf",    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b100, 1'b1, 64'hFFFF_FFFF_8000_0000, 35, 0};
        vecs[13] = '{"divu_big",    64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b001, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 67, 0};
        vecs[14] = '{"divu_restart",64'd100, 64'd7, 3'b101, 1'b0, 64'd14, 67, 11};
        vecs[15] = '{"remu_start_in_done", 64'd100, 64'd7, 3'b111, 1'b0, 64'd2, 67, 67};

        #12;
        check("reset_outputs", {result[61:0], busy, done}, 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) run_op(vecs[i]);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        srcA = 64'd100; srcB = 64'd7; ctrl = 3'b100; isword = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 21; k++) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        check("async_reset_done", {63'd0, done}, 64'd0);
        check("async_reset_result", result, 64'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        no_done = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done || busy) no_done++;
        end
        check("no_done_after_reset", 64'(no_done), 64'd0);
        last_exp = '0;
        run_op('{"fresh_after_reset", 64'd100, 64'd7, 3'b111, 1'b0, 64'd2, 67, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
